modn_counter_disp: RTL

- Parametrised successor of the team's fixed mod-8 JK counter.
- Synchronous modulo-N up/down counter with:
  - built-in clock prescaler,
  - enable,
  - parallel load,
  - terminal-count pulse,
  - integrated 7-segment hex decode of the low nibble.
- Sits between the board clock and the on-board 7-segment display and LEDs; replaces the ripple-divider-plus-JK arrangement with one clocked block.

---
 rtl/modn_counter_disp_if.sv | 24 ++
 rtl/modn_counter_disp.sv | 121 ++++++++++++
 2 files changed

// File: rtl/modn_counter_disp_if.sv
// Bus between the mod-N counter and its user: control strobes in, count/pulses/segments out.
// The master drives the controls; the counter presents the slave view.
interface modn_counter_disp_if #(
    parameter int WIDTH = 4
) ();
    logic             iEn;
    logic             iUp;
    logic             iLoad;
    logic [WIDTH-1:0] iLoadVal;
    logic [WIDTH-1:0] oQ;
    logic             oTick;
    logic             oTC;
    logic [6:0]       oDisplay;

    modport master (
        output iEn, iUp, iLoad, iLoadVal,
        input  oQ, oTick, oTC, oDisplay
    );

    modport slave (
        input  iEn, iUp, iLoad, iLoadVal,
        output oQ, oTick, oTC, oDisplay
    );
endinterface

// File: rtl/modn_counter_disp.sv
// Modulo-N up/down counter with an enable-gated prescaler, clamped parallel load,
// tick/terminal-count pulses and a 7-segment hex decode of the low nibble.
module modn_counter_disp #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10,
    parameter int DIV     = 2
) (
    input  logic                 CLK,
    input  logic                 rst,
    modn_counter_disp_if.slave   bus
);
    localparam int               PW    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
    localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    logic [PW-1:0]    pre_r;
    logic [PW-1:0]    pre_next_s;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;
    logic             tick_r;
    logic             tick_next_s;
    logic             tc_r;
    logic             tc_next_s;
    logic [6:0]       display_r;
    logic [3:0]       nib_next_s;

    // Decode of the next count so the registered segments change on the same edge as oQ.
    generate
        if (WIDTH >= 4) begin : g_nib_wide
            assign nib_next_s = q_next_s[3:0];
        end else begin : g_nib_narrow
            assign nib_next_s = {{(4 - WIDTH){1'b0}}, q_next_s};
        end
    endgenerate

    // Next-state: load beats tick beats hold; a coinciding tick is dropped by the load branch.
    always_comb begin
        pre_next_s  = pre_r;
        q_next_s    = q_r;
        tick_next_s = 1'b0;
        tc_next_s   = 1'b0;
        if (bus.iLoad) begin
            pre_next_s = {PW{1'b0}};
            if (bus.iLoadVal > MAX_Q) begin
                q_next_s = MAX_Q;
            end else begin
                q_next_s = bus.iLoadVal;
            end
        end else if (bus.iEn) begin
            if (pre_r == PRE_LAST) begin
                pre_next_s  = {PW{1'b0}};
                tick_next_s = 1'b1;
                if (bus.iUp) begin
                    if (q_r == MAX_Q) begin
                        q_next_s  = {WIDTH{1'b0}};
                        tc_next_s = 1'b1;
                    end else begin
                        q_next_s = q_r + WIDTH'(1);
                    end
                end else begin
                    if (q_r == {WIDTH{1'b0}}) begin
                        q_next_s  = MAX_Q;
                        tc_next_s = 1'b1;
                    end else begin
                        q_next_s = q_r - WIDTH'(1);
                    end
                end
            end else begin
                pre_next_s = pre_r + PW'(1);
            end
        end else begin
            pre_next_s = pre_r;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (rst) begin
            pre_r     <= {PW{1'b0}};
            q_r       <= {WIDTH{1'b0}};
            tick_r    <= 1'b0;
            tc_r      <= 1'b0;
            display_r <= 7'h3F;
        end else begin
            pre_r     <= pre_next_s;
            q_r       <= q_next_s;
            tick_r    <= tick_next_s;
            tc_r      <= tc_next_s;
            display_r <= seg_decode(nib_next_s);
        end
    end

    assign bus.oQ       = q_r;
    assign bus.oTick    = tick_r;
    assign bus.oTC      = tc_r;
    assign bus.oDisplay = display_r;
endmodule
